// File: rtl/cr_crcgc_stat_accum_if.sv
// Read port between the register/stats block (master) and the checksum event
// accumulator (slave): one request per cycle, one registered ack per request.
interface cr_crcgc_stat_accum_if #(
  parameter int N_EVENTS  = 8,
  parameter int CNT_WIDTH = 32
);
  localparam int AW = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1;

  logic                 rd_req;
  logic [AW-1:0]        rd_addr;
  logic                 rd_clr;
  logic                 rd_ack;
  logic [CNT_WIDTH-1:0] rd_data;
  logic                 rd_ovf;

  modport master (output rd_req, rd_addr, rd_clr, input rd_ack, rd_data, rd_ovf);
  modport slave  (input rd_req, rd_addr, rd_clr, output rd_ack, rd_data, rd_ovf);
endinterface

// File: rtl/cr_crcgc_stat_accum.sv
// Per-event counters for the CRC generate/check status pulses, with sticky overflow
// and a clear-on-read port. Define CR_CRCGC_STAT_SATURATE_EN for saturating counters.
module cr_crcgc_stat_accum #(
  parameter int N_EVENTS  = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_EVENTS-1:0]  crcgc_stat_events,
  input  logic                 stats_freeze,
  cr_crcgc_stat_accum_if.slave rd,
  output logic [N_EVENTS-1:0]  ovf_vec,
  output logic                 err_pulse
);
  localparam int AW = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1;

  function automatic logic [N_EVENTS-1:0] err_mask_f();
    logic [N_EVENTS-1:0] m;
    m = '0;
    for (int i = 1; i < N_EVENTS; i += 2) m[i] = 1'b1;
    return m;
  endfunction

  // MSB of the result flags an overflow event for this increment.
  function automatic logic [CNT_WIDTH:0] incr_f(input logic [CNT_WIDTH-1:0] c);
`ifdef CR_CRCGC_STAT_SATURATE_EN
    return (&c) ? {1'b1, c} : {1'b0, c + CNT_WIDTH'(1)};
`else
    return {1'b0, c} + (CNT_WIDTH+1)'(1);
`endif
  endfunction

  localparam logic [N_EVENTS-1:0] ERR_MASK = err_mask_f();

  logic [N_EVENTS-1:0]  ev_q;
  logic [CNT_WIDTH-1:0] cnt_q [N_EVENTS];
  logic [CNT_WIDTH-1:0] cnt_d [N_EVENTS];
  logic [N_EVENTS-1:0]  ovf_q, ovf_d;
  logic [N_EVENTS-1:0]  clr_hit;
  logic [CNT_WIDTH:0]   inc;
  logic [CNT_WIDTH-1:0] sel_cnt;
  logic                 sel_ovf;
  logic                 err_q;
  logic                 rd_ack_q;
  logic [CNT_WIDTH-1:0] rd_data_q;
  logic                 rd_ovf_q;

  // Out-of-range addresses match no index, so they read zero and clear nothing.
  always_comb begin
    sel_cnt = '0;
    sel_ovf = 1'b0;
    inc     = '0;
    clr_hit = '0;
    for (int i = 0; i < N_EVENTS; i++) begin
      clr_hit[i] = rd.rd_req & rd.rd_clr & (rd.rd_addr == AW'(i));
      inc        = incr_f(cnt_q[i]);
      cnt_d[i]   = cnt_q[i];
      ovf_d[i]   = ovf_q[i];
      if (clr_hit[i]) begin
        cnt_d[i] = CNT_WIDTH'(ev_q[i]);
        ovf_d[i] = 1'b0;
      end else if (ev_q[i]) begin
        cnt_d[i] = inc[CNT_WIDTH-1:0];
        ovf_d[i] = ovf_q[i] | inc[CNT_WIDTH];
      end
      if (rd.rd_addr == AW'(i)) begin
        sel_cnt = cnt_q[i];
        sel_ovf = ovf_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_q      <= '0;
      cnt_q     <= '{default: '0};
      ovf_q     <= '0;
      err_q     <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      rd_ovf_q  <= 1'b0;
    end else begin
      ev_q     <= stats_freeze ? '0 : crcgc_stat_events;
      err_q    <= |(ev_q & ERR_MASK);
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      rd_ack_q <= rd.rd_req;
      if (rd.rd_req) begin
        rd_data_q <= sel_cnt;
        rd_ovf_q  <= sel_ovf;
      end
    end
  end

  assign rd.rd_ack  = rd_ack_q;
  assign rd.rd_data = rd_data_q;
  assign rd.rd_ovf  = rd_ovf_q;
  assign ovf_vec    = ovf_q;
  assign err_pulse  = err_q;
endmodule

// File: tb/tb_cr_crcgc_stat_accum.sv
// Bench for cr_crcgc_stat_accum: per-cycle vector table plus overflow and reset sequences,
// read results checked against a scoreboard queue as rd_ack arrives.
module tb_cr_crcgc_stat_accum;
  localparam int NE = 8;
  localparam int CW = 4;
  localparam int NV = 33;
`ifdef CR_CRCGC_STAT_SATURATE_EN
  localparam logic [CW-1:0] OVF_CNT = 4'hF;
`else
  localparam logic [CW-1:0] OVF_CNT = 4'h0;
`endif

  typedef struct {
    logic [7:0]    ev;
    logic          frz;
    logic          req;
    logic [2:0]    addr;
    logic          clr;
    logic [CW-1:0] xd;
    logic          xo;
    logic          xe;
  } vec_t;

  typedef struct {
    logic [CW-1:0] d;
    logic          o;
  } rd_exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NE-1:0] ev;
  logic          frz;
  logic [NE-1:0] ovf_vec;
  logic          err_pulse;
  int            n_chk = 0;
  int            n_fail = 0;
  rd_exp_t       sb[$];
  vec_t          tbl[NV];

  cr_crcgc_stat_accum_if #(.N_EVENTS(NE), .CNT_WIDTH(CW)) rd_if();

  cr_crcgc_stat_accum #(.N_EVENTS(NE), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .crcgc_stat_events(ev),
    .stats_freeze     (frz),
    .rd               (rd_if.slave),
    .ovf_vec          (ovf_vec),
    .err_pulse        (err_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] e, input logic f, input logic r, input logic [2:0] a,
                       input logic c, input logic [CW-1:0] xd, input logic xo);
    rd_exp_t x;
    ev = e; frz = f;
    rd_if.rd_req = r; rd_if.rd_addr = a; rd_if.rd_clr = c;
    if (r) begin
      x.d = xd; x.o = xo;
      sb.push_back(x);
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    rd_exp_t x;
    if (rd_if.rd_ack === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rd_ack", 1, 0);
      end else begin
        x = sb.pop_front();
        check("rd_data", rd_if.rd_data, x.d);
        check("rd_ovf", rd_if.rd_ovf, x.o);
      end
    end
  end

  initial begin
    for (int k = 0; k < NV; k++) begin
      tbl[k].ev = '0; tbl[k].frz = 0; tbl[k].req = 0; tbl[k].addr = 0;
      tbl[k].clr = 0; tbl[k].xd = 0; tbl[k].xo = 0; tbl[k].xe = 0;
    end
    tbl[0].ev = 8'h01;
    tbl[2].req = 1; tbl[2].clr = 1; tbl[2].xd = 1;
    for (int k = 3; k <= 7; k++) tbl[k].ev = 8'hFF;
    for (int k = 4; k <= 8; k++) tbl[k].xe = 1;
    for (int k = 0; k < 8; k++) begin
      tbl[9+k].req = 1; tbl[9+k].addr = 3'(k); tbl[9+k].xd = 5;
    end
    for (int k = 17; k <= 22; k++) tbl[k].ev = 8'h08;
    for (int k = 18; k <= 23; k++) tbl[k].xe = 1;
    tbl[23].req = 1; tbl[23].addr = 3; tbl[23].clr = 1; tbl[23].xd = 10;
    tbl[24].req = 1; tbl[24].addr = 3; tbl[24].xd = 1;
    for (int k = 25; k <= 28; k++) begin tbl[k].ev = 8'h40; tbl[k].frz = 1; end
    tbl[25].req = 1; tbl[25].addr = 6; tbl[25].clr = 1; tbl[25].xd = 5;
    tbl[29].ev = 8'h40; tbl[30].ev = 8'h40;
    tbl[32].req = 1; tbl[32].addr = 6; tbl[32].xd = 2;

    rst = 1; ev = '0; frz = 0;
    rd_if.rd_req = 0; rd_if.rd_addr = '0; rd_if.rd_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_ack", rd_if.rd_ack, 0);
    check("reset_rd_data", rd_if.rd_data, 0);
    check("reset_rd_ovf", rd_if.rd_ovf, 0);
    check("reset_ovf_vec", ovf_vec, 0);
    check("reset_err_pulse", err_pulse, 0);
    rst = 0;

    for (int k = 0; k < NV; k++) begin
      drive(tbl[k].ev, tbl[k].frz, tbl[k].req, tbl[k].addr, tbl[k].clr, tbl[k].xd, tbl[k].xo);
      check($sformatf("err_pulse[%0d]", k), err_pulse, tbl[k].xe);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rd_data_hold", rd_if.rd_data, 2);
    check("ovf_vec_none", ovf_vec, 0);

    // Overflow on counter 2: start from zero, push 16 pulses.
    drive(0, 0, 1, 2, 1, 5, 0);
    for (int k = 0; k < 16; k++) drive(8'h04, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("ovf_vec_set", ovf_vec, 8'h04);
    drive(0, 0, 1, 2, 1, OVF_CNT, 1);
    check("ovf_vec_clr", ovf_vec, 0);
    drive(0, 0, 1, 2, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Reset while ev_q holds an error event and a read is pending.
    drive(8'h03, 0, 0, 0, 0, 0, 0);
    rst = 1; ev = '0; rd_if.rd_req = 1; rd_if.rd_addr = 0; rd_if.rd_clr = 0;
    @(posedge clk); #1;
    check("rst_no_ack", rd_if.rd_ack, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_ovf_vec", ovf_vec, 0);
    rst = 0; rd_if.rd_req = 0;
    @(posedge clk); #1;
    check("rst_err_next", err_pulse, 0);
    for (int k = 0; k < NE; k++) drive(0, 0, 1, 3'(k), 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("reads_all_acked", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cr_crcgc_stat_accum.md
# cr_crcgc_stat_accum

Accumulates the eight single-cycle checksum status event pulses produced by the CRC generate/check core (raw-data, CRC64E, encrypted/compressed-data and NVMe raw checksum good/error) into per-event counters. Sits directly downstream of the CRC generate/check core's `crcgc_stat_events` output. Provides a registered read port with optional clear-on-read for the register/stats block. Keeps a sticky overflow flag per counter.

## Interface
- `N_EVENTS`, 8, number of event inputs; bit order matches `crcgc_stat_events` (0 = raw good … 7 = NVMe raw error).
- `CNT_WIDTH`, 32, width of each event counter.
- `clk`  input  1  block clock.
- `rst`  input  1  reset: synchronous, active-high, single clock domain.
- `crcgc_stat_events`  input  N_EVENTS  one-cycle event pulses; any combination may be high in one cycle.
- `stats_freeze`  input  1  when high, newly sampled events are discarded; counters hold.
- `rd_req`  input  1  read request, one per cycle, back-to-back allowed.
- `rd_addr`  input  $clog2(N_EVENTS)  counter index.
- `rd_clr`  input  1  clear the addressed counter and its overflow flag with this read.
- `rd_ack`  output  1  read data valid, exactly one pulse per accepted `rd_req`.
- `rd_data`  output  CNT_WIDTH  counter value returned for the read.
- `rd_ovf`  output  1  overflow flag of the addressed counter, returned with `rd_data`.
- `ovf_vec`  output  N_EVENTS  live sticky overflow flags.
- `err_pulse`  output  1  registered OR of event bits 1, 3, 5, 7 after the input stage; forwarded for interrupt logic.

## Operation
- **Input stage:**
  - `ev_q <= stats_freeze ? 0 : crcgc_stat_events`, sampled every cycle.
  - `err_pulse <= |(ev_q & 8'hAA)`.
- **Counter update**, per counter i, each cycle, in priority order:
  - Clear hit: `rd_req & rd_clr & rd_addr == i`. Then `cnt[i] <= ev_q[i]` and `ovf[i] <= 0`. An increment arriving in the clear cycle is retained as a count of 1, never lost.
  - Else if `ev_q[i]` is high: increment. Overflow handling per Configuration.
  - Else hold.
- **Read:**
  - On `rd_req`, `rd_data <= cnt[rd_addr]` and `rd_ovf <= ovf[rd_addr]`. Both are the values before this cycle's update.
  - `rd_ack <= rd_req`.
  - `rd_data` and `rd_ovf` hold their last value while `rd_ack` is low.
- **Out-of-range `rd_addr`** (≥ N_EVENTS, when N_EVENTS is not a power of 2):
  - `rd_data = 0`, `rd_ovf = 0`, `rd_ack` still pulses.
  - No counter is cleared.
- **No backpressure.** All events are counted unless frozen or in reset.
- **Reset:** all counters, `ovf`, `ev_q`, `err_pulse`, `rd_ack`, `rd_data`, `rd_ovf` go to 0. A pulse in `ev_q` or a pending read is dropped, and no `rd_ack` is produced for it.

## Timing
- Event pulse in cycle N → `ev_q` high in cycle N+1 → counter shows the new value in cycle N+2.
- Read latency: `rd_req` in cycle M → `rd_ack`/`rd_data` in cycle M+1. The value reflects events sampled up to cycle M−2.
- A clear-on-read in cycle M → counter is 0 (or 1, if `ev_q` was set in M) from cycle M+1.
- `err_pulse` rises in cycle N+2 for an error event pulse in cycle N.
- `stats_freeze` takes effect on events in the same cycle. An event already in `ev_q` still counts.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- `CR_CRCGC_STAT_SATURATE_EN` defined:
  - A counter at all-ones holds at all-ones on increment.
  - `ovf[i]` is set on the first attempted increment at max.
- Not defined:
  - A counter at all-ones wraps to 0 on increment.
  - `ovf[i]` is set on the wrap.
- In both cases `ovf` is sticky until a clear-on-read of that counter or reset.

## Test plan
- **Single event, then read.** `crcgc_stat_events = 8'h01` for 1 cycle at N; `rd_req`, addr 0 at N+2.
  - `rd_ack` at N+3 with `rd_data = 1`, `rd_ovf = 0`.
- **Simultaneous events.** `8'hFF` for 5 consecutive cycles.
  - Reading each of the 8 counters back-to-back returns 5 in consecutive cycles, one `rd_ack` per request.
  - `err_pulse` is high for 5 cycles.
- **Clear collides with increment.** Counter 3 = 10; `ev_q[3]` high in the same cycle as `rd_req` with `rd_clr`, addr 3.
  - Read returns 10.
  - A read the next cycle returns 1.
- **Overflow.** `CNT_WIDTH = 4`; 16 pulses on bit 2.
  - With the macro: counter = 15, `ovf_vec[2] = 1`.
  - Without the macro: counter = 0, `ovf_vec[2] = 1`.
  - Either case: clear-on-read then drops `ovf_vec[2]` to 0.
- **Freeze.** `stats_freeze` high during 4 pulses on bit 6, low during 2 further pulses.
  - Counter 6 = 2.
- **Reset mid-operation.** `rst` high in the cycle `ev_q[0]` is set and a `rd_req` is pending.
  - No `rd_ack`.
  - All counters and `ovf_vec` = 0.
  - `err_pulse = 0` the next cycle.
